// File: rtl/ras_param_stack.sv
// Return-address stack: DEPTH x AW circular stack with wrap-on-overflow, checkpoint/recover.
// Optional macro RAS_REPAIR_EN: recover also rewrites entry[e_recover_index] with e_recover_top.
module ras_param_stack_entry #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module ras_param_stack #(
  parameter int DEPTH = 16,
  parameter int AW    = 32,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_valid,
  input  logic          f_push,
  input  logic          f_pop,
  input  logic [AW-1:0] f_push_addr,
  output logic [AW-1:0] f_top_addr,
  output logic          f_top_valid,
  output logic [IW-1:0] f_ckpt_index,
  output logic [IW:0]   f_ckpt_count,
  output logic [AW-1:0] f_ckpt_top,
  input  logic          e_recover,
  input  logic [IW-1:0] e_recover_index,
  input  logic [IW:0]   e_recover_count,
  input  logic [AW-1:0] e_recover_top,
  output logic          ras_full,
  output logic          ras_empty
);
  localparam logic [IW:0] FULL_CNT = (IW+1)'(DEPTH);

  logic [IW-1:0]             tos, nxt_tos, wr_idx;
  logic [IW:0]               cnt, nxt_cnt;
  logic                      wr_en;
  logic [AW-1:0]             wr_data;
  logic [DEPTH-1:0][AW-1:0]  ent;
  logic [DEPTH-1:0]          ent_we;

  always_comb begin
    nxt_tos = tos;
    nxt_cnt = cnt;
    wr_en   = 1'b0;
    wr_idx  = tos;
    wr_data = f_push_addr;
    if (e_recover) begin
      nxt_tos = e_recover_index;
      nxt_cnt = (e_recover_count > FULL_CNT) ? FULL_CNT : e_recover_count;
`ifdef RAS_REPAIR_EN
      wr_en   = 1'b1;
      wr_idx  = e_recover_index;
      wr_data = e_recover_top;
`endif
    end else if (f_valid) begin
      unique case ({f_push, f_pop})
        2'b10: begin
          // Full stack keeps count saturated; the wrapped write replaces the oldest entry.
          nxt_tos = tos + IW'(1);
          wr_en   = 1'b1;
          wr_idx  = tos + IW'(1);
          nxt_cnt = (cnt == FULL_CNT) ? cnt : cnt + (IW+1)'(1);
        end
        2'b01: begin
          if (cnt != '0) begin
            nxt_tos = tos - IW'(1);
            nxt_cnt = cnt - (IW+1)'(1);
          end
        end
        2'b11: begin
          // Return-then-call: the popped slot is immediately refilled in place.
          wr_en   = 1'b1;
          nxt_cnt = (cnt == '0) ? (IW+1)'(1) : cnt;
        end
        default: ;
      endcase
    end
  end

`ifndef RAS_REPAIR_EN
  logic unused_top;
  assign unused_top = ^e_recover_top;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tos <= '0;
      cnt <= '0;
    end else begin
      tos <= nxt_tos;
      cnt <= nxt_cnt;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_we[i] = wr_en && (wr_idx == IW'(i));
    ras_param_stack_entry #(.AW(AW)) u_ent (
      .clk   (clk),
      .reset (reset),
      .we    (ent_we[i]),
      .d     (wr_data),
      .q     (ent[i])
    );
  end

  assign f_top_valid  = (cnt != '0);
  assign f_top_addr   = f_top_valid ? ent[tos] : '0;
  assign f_ckpt_index = tos;
  assign f_ckpt_count = cnt;
  assign f_ckpt_top   = ent[tos];
  assign ras_full     = (cnt == FULL_CNT);
  assign ras_empty    = (cnt == '0);
endmodule

// File: tb/tb_ras_param_stack.sv
// Bench for ras_param_stack: directed scenarios plus random traffic against an array-based model.
module tb_ras_param_stack;
  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int IW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_valid, f_push, f_pop;
  logic [AW-1:0] f_push_addr;
  logic [AW-1:0] f_top_addr;
  logic          f_top_valid;
  logic [IW-1:0] f_ckpt_index;
  logic [IW:0]   f_ckpt_count;
  logic [AW-1:0] f_ckpt_top;
  logic          e_recover;
  logic [IW-1:0] e_recover_index;
  logic [IW:0]   e_recover_count;
  logic [AW-1:0] e_recover_top;
  logic          ras_full, ras_empty;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain array, integer pointer and occupancy.
  logic [AW-1:0] m_ent [DEPTH];
  int            m_tos, m_cnt;

  always #5 clk = ~clk;

  ras_param_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_push(f_push), .f_pop(f_pop), .f_push_addr(f_push_addr),
    .f_top_addr(f_top_addr), .f_top_valid(f_top_valid),
    .f_ckpt_index(f_ckpt_index), .f_ckpt_count(f_ckpt_count), .f_ckpt_top(f_ckpt_top),
    .e_recover(e_recover), .e_recover_index(e_recover_index),
    .e_recover_count(e_recover_count), .e_recover_top(e_recover_top),
    .ras_full(ras_full), .ras_empty(ras_empty)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_ent[i] = '0;
    m_tos = 0;
    m_cnt = 0;
  endtask

  task automatic model_step(input logic v, pu, po, input logic [AW-1:0] a,
                            input logic rec, input int ridx, input int rcnt,
                            input logic [AW-1:0] rtop);
    if (rec) begin
      m_tos = ridx;
      m_cnt = (rcnt > DEPTH) ? DEPTH : rcnt;
`ifdef RAS_REPAIR_EN
      m_ent[ridx] = rtop;
`endif
    end else if (v) begin
      if (pu && !po) begin
        m_tos = (m_tos + 1) % DEPTH;
        m_ent[m_tos] = a;
        m_cnt = (m_cnt == DEPTH) ? DEPTH : m_cnt + 1;
      end else if (po && !pu) begin
        if (m_cnt > 0) begin
          m_tos = (m_tos + DEPTH - 1) % DEPTH;
          m_cnt = m_cnt - 1;
        end
      end else if (po && pu) begin
        m_ent[m_tos] = a;
        if (m_cnt == 0) m_cnt = 1;
      end
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".top"},   f_top_addr,   (m_cnt != 0) ? m_ent[m_tos] : '0);
    chk({tag, ".tv"},    f_top_valid,  m_cnt != 0);
    chk({tag, ".idx"},   f_ckpt_index, m_tos);
    chk({tag, ".cnt"},   f_ckpt_count, m_cnt);
    chk({tag, ".ctop"},  f_ckpt_top,   m_ent[m_tos]);
    chk({tag, ".full"},  ras_full,     m_cnt == DEPTH);
    chk({tag, ".empty"}, ras_empty,    m_cnt == 0);
  endtask

  // Called #1 after a rising edge; drives one cycle and checks the result after the next edge.
  task automatic step(input string tag, input logic v, pu, po, input logic [AW-1:0] a,
                      input logic rec, input int ridx, input int rcnt, input logic [AW-1:0] rtop);
    f_valid = v; f_push = pu; f_pop = po; f_push_addr = a;
    e_recover = rec; e_recover_index = IW'(ridx); e_recover_count = (IW+1)'(rcnt);
    e_recover_top = rtop;
    @(posedge clk);
    model_step(v, pu, po, a, rec, ridx, rcnt, rtop);
    #1;
    f_valid = 1'b0; f_push = 1'b0; f_pop = 1'b0; e_recover = 1'b0;
    chk_state(tag);
  endtask

  task automatic push(input logic [AW-1:0] a); step("push", 1, 1, 0, a, 0, 0, 0, 0); endtask
  task automatic pop();                        step("pop",  1, 0, 1, 0, 0, 0, 0, 0); endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    f_valid = 0; f_push = 0; f_pop = 0; f_push_addr = '0;
    e_recover = 0; e_recover_index = '0; e_recover_count = '0; e_recover_top = '0;
    model_reset();
    #12;
    chk("rst.top", f_top_addr, 0);
    chk("rst.tv", f_top_valid, 0);
    chk("rst.empty", ras_empty, 1);
    chk("rst.full", ras_full, 0);
    chk("rst.cnt", f_ckpt_count, 0);
    chk("rst.idx", f_ckpt_index, 0);
    chk("rst.ctop", f_ckpt_top, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: basic push/pop
    push(32'h100); push(32'h200); push(32'h300);
    chk("t1.top", f_top_addr, 32'h300);
    chk("t1.cnt", f_ckpt_count, 3);
    pop();
    chk("t1.pop_top", f_top_addr, 32'h200);
    chk("t1.pop_cnt", f_ckpt_count, 2);

    // 2: overflow wrap then drain past empty
    do_reset();
    for (int k = 1; k <= 17; k++) push(32'(4 * k));
    chk("t2.cnt", f_ckpt_count, 16);
    chk("t2.full", ras_full, 1);
    chk("t2.top", f_top_addr, 32'h44);
    for (int k = 0; k < 16; k++) begin
      pop();
      if (k < 15) chk("t2.drain_top", f_top_addr, 32'(4 * (16 - k)));
    end
    chk("t2.empty", ras_empty, 1);
    pop();
    chk("t2.extra_tv", f_top_valid, 0);
    chk("t2.extra_cnt", f_ckpt_count, 0);

    // 3: push+pop same cycle
    do_reset();
    push(32'h100); push(32'h200);
    step("t3", 1, 1, 1, 32'h500, 0, 0, 0, 0);
    chk("t3.top", f_top_addr, 32'h500);
    chk("t3.cnt", f_ckpt_count, 2);
    chk("t3.idx", f_ckpt_index, 2);

    // 4: checkpoint, wrong-path pop/push, recover
    do_reset();
    push(32'h100); push(32'h200);
    chk("t4.ck_idx", f_ckpt_index, 2);
    chk("t4.ck_top", f_ckpt_top, 32'h200);
    pop();
    push(32'h900);
    step("t4.rec", 0, 0, 0, 0, 1, 2, 2, 32'h200);
`ifdef RAS_REPAIR_EN
    chk("t4.top", f_top_addr, 32'h200);
`else
    chk("t4.top", f_top_addr, 32'h900);
`endif
    chk("t4.cnt", f_ckpt_count, 2);

    // 5: recover wins over a simultaneous push
    step("t5", 1, 1, 0, 32'hdead, 1, 1, 1, 32'h100);
    chk("t5.cnt", f_ckpt_count, 1);
    chk("t5.idx", f_ckpt_index, 1);
    chk("t5.top", f_top_addr, 32'h100);

    // recover count above DEPTH clamps
    step("clamp", 0, 0, 0, 0, 1, 3, 31, 32'h77);
    chk("clamp.cnt", f_ckpt_count, 16);

    // 6: asynchronous reset between edges
    push(32'habc);
    #2 reset = 1'b0;
    #1;
    chk("t6.cnt", f_ckpt_count, 0);
    chk("t6.tv", f_top_valid, 0);
    chk("t6.empty", ras_empty, 1);
    model_reset();
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // 7: stalled fetch ignores push/pop
    push(32'h10); push(32'h20);
    step("t7", 0, 1, 1, 32'hbad, 0, 0, 0, 0);
    chk("t7.top", f_top_addr, 32'h20);
    chk("t7.cnt", f_ckpt_count, 2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic rv, rpu, rpo, rrec;
      rv   = ($urandom_range(0, 9) < 8);
      rpu  = $urandom_range(0, 1);
      rpo  = $urandom_range(0, 1);
      rrec = ($urandom_range(0, 15) == 0);
      step("rnd", rv, rpu, rpo, $urandom, rrec,
           $urandom_range(0, DEPTH - 1), $urandom_range(0, 31), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
